// File: rtl/reg_writeback.sv
// reg_writeback -- write-back end of the MIPS register file.
//
// Owns the 32x32 architectural register array and gives decode two
// combinational read ports. When the sequencer presents the write-back
// stage, a four-state FSM (IDLE -> COMMIT -> DONE -> [HOLD] -> IDLE)
// captures the destination and the result once, writes the array on the
// following edge, and pulses wb_done for one cycle. A stage held at
// write-back never produces a second commit.
//
// Register 0 is hardwired to zero. Writes to it are dropped and are not
// counted.
//
// Optional feature: define WB_BYPASS_EN to forward write_data to a read
// port that addresses the register being written during the COMMIT cycle.
// Without the macro, the read ports show the array contents only.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   stage               current pipeline stage from the sequencer
//   regWrite            control: the result is to be written
//   regDest             control: 1 selects rd as destination, 0 selects rt
//   memToReg            control: 1 selects mem_read_data, 0 selects alu_result
//   rt, rd              register fields of the current instruction
//   alu_result          ALU output
//   mem_read_data       data memory output
//   read_reg_1/2        decode read addresses
//   read_data_1/2       decode read data (combinational)
//   wb_done             one-cycle pulse in the cycle after the commit edge
//   write_reg           last captured destination register
//   write_data          last captured write data
//   write_count         number of register writes actually performed
module reg_writeback #(
  parameter int         DATA_W   = 32,
  parameter int         NUM_REGS = 32,
  parameter logic [2:0] WB_STAGE = 3'd4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        stage,
  input  logic              regWrite,
  input  logic              regDest,
  input  logic              memToReg,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [4:0]        read_reg_1,
  input  logic [4:0]        read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              wb_done,
  output logic [4:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [15:0]       write_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DONE   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic              we_r;
  logic [4:0]        write_reg_r;
  logic [DATA_W-1:0] write_data_r;
  logic [15:0]       write_count_r;
  logic              wb_done_r;

  logic              commit_en_s;
  logic              fwd_1_s;
  logic              fwd_2_s;
  logic [DATA_W-1:0] read_data_1_s;
  logic [DATA_W-1:0] read_data_2_s;

  // A captured write only lands when enabled and not aimed at register 0.
  assign commit_en_s = we_r && (write_reg_r != 5'd0);

`ifdef WB_BYPASS_EN
  assign fwd_1_s = (state_r == COMMIT) && commit_en_s && (read_reg_1 == write_reg_r);
  assign fwd_2_s = (state_r == COMMIT) && commit_en_s && (read_reg_2 == write_reg_r);
`else
  assign fwd_1_s = 1'b0;
  assign fwd_2_s = 1'b0;
`endif

  // Write-back sequencer: capture in IDLE, write in COMMIT, pulse in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      we_r          <= 1'b0;
      write_reg_r   <= 5'd0;
      write_data_r  <= {DATA_W{1'b0}};
      write_count_r <= 16'd0;
      wb_done_r     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      wb_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (stage == WB_STAGE) begin
            write_reg_r  <= regDest ? rd : rt;
            write_data_r <= memToReg ? mem_read_data : alu_result;
            we_r         <= regWrite;
            state_r      <= COMMIT;
          end else begin
            state_r <= IDLE;
          end
        end
        COMMIT: begin
          if (commit_en_s) begin
            regs_r[write_reg_r] <= write_data_r;
            write_count_r       <= write_count_r + 16'd1;
          end
          // The pulse registered here is visible throughout DONE.
          wb_done_r <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          state_r <= (stage == WB_STAGE) ? HOLD : IDLE;
        end
        HOLD: begin
          // Parking here is what stops a lingering stage from recommitting.
          state_r <= (stage == WB_STAGE) ? HOLD : IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Read port 1: register 0 reads zero, then optional forwarding, then array.
  always_comb begin
    read_data_1_s = {DATA_W{1'b0}};
    if (read_reg_1 == 5'd0) begin
      read_data_1_s = {DATA_W{1'b0}};
    end else if (fwd_1_s) begin
      read_data_1_s = write_data_r;
    end else begin
      read_data_1_s = regs_r[read_reg_1];
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    read_data_2_s = {DATA_W{1'b0}};
    if (read_reg_2 == 5'd0) begin
      read_data_2_s = {DATA_W{1'b0}};
    end else if (fwd_2_s) begin
      read_data_2_s = write_data_r;
    end else begin
      read_data_2_s = regs_r[read_reg_2];
    end
  end

  assign read_data_1 = read_data_1_s;
  assign read_data_2 = read_data_2_s;
  assign wb_done     = wb_done_r;
  assign write_reg   = write_reg_r;
  assign write_data  = write_data_r;
  assign write_count = write_count_r;

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-back end of the MIPS register file: the writer counterpart to the decode stage's register reads.
- Owns the 32x32 architectural register array. Exposes two asynchronous read ports to decode.
- Commits the write-back result (ALU result or memory load data) into rt or rd, as selected by the control signals, when the stage sequencer reaches the write-back stage.
- A small FSM guarantees exactly one commit per write-back stage visit and produces a done pulse for the sequencer.

Parameters:
- DATA_W, 32, register data width
- NUM_REGS, 32, register count; address width is 5, fixed
- WB_STAGE, 3'd4, stage encoding that triggers write-back

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stage  input  3  current pipeline stage from the sequencer
- regWrite  input  1  control: result is to be written
- regDest  input  1  control: 1 = destination rd, 0 = destination rt
- memToReg  input  1  control: 1 = data from mem_read_data, 0 = data from alu_result
- rt  input  5  rt field of the current instruction
- rd  input  5  rd field of the current instruction
- alu_result  input  DATA_W  ALU output
- mem_read_data  input  DATA_W  data memory output
- read_reg_1  input  5  read address port 1 (decode rs)
- read_reg_2  input  5  read address port 2 (decode rt)
- read_data_1  output  DATA_W  register[read_reg_1]
- read_data_2  output  DATA_W  register[read_reg_2]
- wb_done  output  1  one-cycle pulse after the commit cycle
- write_reg  output  5  last captured destination register
- write_data  output  DATA_W  last captured write data
- write_count  output  16  number of register writes actually performed

Behaviour:
Reset (asynchronous, any state):
- All registers cleared to 0; state goes to IDLE.
- wb_done=0, write_reg=0, write_data=0, write_count=0.
- A pending COMMIT is aborted with no write.

FSM states: IDLE, COMMIT, DONE, HOLD.
- IDLE: on a posedge with stage==WB_STAGE, capture the following, then go to COMMIT.
  - write_reg = regDest ? rd : rt
  - write_data = memToReg ? mem_read_data : alu_result
  - we_q = regWrite
- IDLE with any other stage: stay in IDLE; no state changes.
- COMMIT: if we_q==1 and write_reg!=0, write register[write_reg] <= write_data and increment write_count (wraps 16'hFFFF -> 0). Go to DONE unconditionally.
- DONE: wb_done=1 for this cycle only. If stage==WB_STAGE go to HOLD, else go to IDLE.
- HOLD: wait until stage!=WB_STAGE, then go to IDLE. A stage held at WB_STAGE never causes a second commit.
- Inputs are sampled only in IDLE; changes during COMMIT/DONE/HOLD are ignored.

Latency: capture at edge N, array write at edge N+1, wb_done high during the cycle after edge N+1.

Register 0:
- Hardwired to zero; writes to it are dropped and do not increment write_count.
- Reads of address 0 always return 0.

Read ports:
- Combinational reads of the array, with the register 0 rule applied.
- Both ports may read the same address.
- A read of the register being written returns the old value until the COMMIT edge, except as provided by the optional feature.

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined: while the state is COMMIT with we_q==1, write_reg!=0, and read_reg_x==write_reg, read_data_x returns write_data (write-through forwarding).
- Undefined: no forwarding; read ports show array contents only.

Test Plan:
- Reset then read all 32 addresses -> all read 0; write_count=0; wb_done=0.
- stage=4, regWrite=1, regDest=1, rd=5, memToReg=0, alu_result=32'h0000_00AA -> register[5]=32'hAA one edge after capture; wb_done pulses once; write_count=1.
- Load write-back: regDest=0, rt=9, memToReg=1, mem_read_data=32'hDEAD_BEEF, stage held at 4 for 6 cycles -> register[9]=32'hDEADBEEF, exactly one wb_done, write_count incremented by 1.
- Writes with rd=0 (regWrite=1), and with regWrite=0 to rd=7 -> register[0] reads 0, register[7] unchanged, write_count unchanged, wb_done still pulses.
- With WB_BYPASS_EN defined: read_reg_1=12 during COMMIT of 32'h1234_5678 to register 12 -> read_data_1=32'h12345678 in the COMMIT cycle. Without the macro -> old value in that cycle.
- Assert rst during COMMIT of 32'h55 to register 3 -> register[3]=0, state IDLE, no wb_done, write_count=0.
